// File: rtl/mem_arbiter_ctrl.sv
// rtl/mem_arbiter_ctrl.sv - N-port round-robin memory access controller with a registered bus read/write FSM
// Optional bus-stall abort is built only when MEM_ARBITER_TIMEOUT_EN is defined.
module mem_arbiter_ctrl #(
   parameter int NUM_PORTS   = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PORTS-1:0]          req_i,
   input  logic [NUM_PORTS-1:0]          we_i,
   input  logic [NUM_PORTS*ADDR_W-1:0]   addr_i,
   input  logic [NUM_PORTS*DATA_W-1:0]   wdata_i,
   input  logic [NUM_PORTS*DATA_W/8-1:0] be_i,
   output logic [NUM_PORTS-1:0]          gnt_o,
   output logic [NUM_PORTS-1:0]          rvalid_o,
   output logic [DATA_W-1:0]             rdata_o,
   output logic [NUM_PORTS-1:0]          err_o,
   output logic [ADDR_W-1:0]             bus_addr_o,
   output logic [DATA_W-1:0]             bus_wdata_o,
   output logic [DATA_W/8-1:0]           bus_be_o,
   output logic                          bus_read_o,
   output logic                          bus_write_o,
   input  logic                          bus_busy_i,
   input  logic [DATA_W-1:0]             bus_rdata_i,
   output logic [1:0]                    state_o
);

   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]     win_q, win_d;
   logic                 we_q, we_d;
   logic [IDX_W-1:0]     sel, cand;
   logic                 found;
   logic [ADDR_W-1:0]    addr_d;
   logic [DATA_W-1:0]    wdata_d, rdata_d;
   logic [BE_W-1:0]      be_d;
   logic                 rd_d, wr_d;
   logic [NUM_PORTS-1:0] gnt_d, rvalid_d;

`ifdef MEM_ARBITER_TIMEOUT_EN
   localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic [NUM_PORTS-1:0] err_d;
`endif

   assign state_o = state_q;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      win_d    = win_q;
      we_d     = we_q;
      addr_d   = bus_addr_o;
      wdata_d  = bus_wdata_o;
      be_d     = bus_be_o;
      rdata_d  = rdata_o;
      rd_d     = 1'b0;
      wr_d     = 1'b0;
      gnt_d    = '0;
      rvalid_d = '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      tmo_d    = tmo_q;
      err_d    = '0;
`endif

      // Search starts one past the last winner so every requester gets a turn.
      sel   = ptr_q;
      cand  = '0;
      found = 1'b0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         cand = IDX_W'((int'(ptr_q) + i) % NUM_PORTS);
         if (!found && req_i[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d    = S_REQ;
               ptr_d      = sel;
               win_d      = sel;
               we_d       = we_i[sel];
               addr_d     = addr_i[sel*ADDR_W +: ADDR_W];
               wdata_d    = wdata_i[sel*DATA_W +: DATA_W];
               be_d       = we_i[sel] ? be_i[sel*BE_W +: BE_W] : '1;
               rd_d       = !we_i[sel];
               wr_d       = we_i[sel];
               gnt_d[sel] = 1'b1;
`ifdef MEM_ARBITER_TIMEOUT_EN
               tmo_d      = '0;
`endif
            end
         end
         S_REQ, S_WAIT: begin
            if (!bus_busy_i) begin
               state_d         = S_DONE;
               rvalid_d[win_q] = 1'b1;
               if (!we_q) rdata_d = bus_rdata_i;
            end else begin
               state_d = S_WAIT;
               rd_d    = !we_q;
               wr_d    = we_q;
`ifdef MEM_ARBITER_TIMEOUT_EN
               if (state_q == S_WAIT) begin
                  if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                     state_d      = S_DONE;
                     rd_d         = 1'b0;
                     wr_d         = 1'b0;
                     err_d[win_q] = 1'b1;
                  end else begin
                     tmo_d = tmo_q + 1'b1;
                  end
               end
`endif
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= IDX_W'(NUM_PORTS - 1);
         win_q       <= '0;
         we_q        <= 1'b0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
         bus_be_o    <= '0;
         bus_read_o  <= 1'b0;
         bus_write_o <= 1'b0;
         rdata_o     <= '0;
         gnt_o       <= '0;
         rvalid_o    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         win_q       <= win_d;
         we_q        <= we_d;
         bus_addr_o  <= addr_d;
         bus_wdata_o <= wdata_d;
         bus_be_o    <= be_d;
         bus_read_o  <= rd_d;
         bus_write_o <= wr_d;
         rdata_o     <= rdata_d;
         gnt_o       <= gnt_d;
         rvalid_o    <= rvalid_d;
      end
   end

`ifdef MEM_ARBITER_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= '0;
         err_o <= '0;
      end else begin
         tmo_q <= tmo_d;
         err_o <= err_d;
      end
   end
`else
   assign err_o = '0;
`endif

endmodule
